// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Control FSM for the instruction fetch stage. Each cycle it
//            decides whether the PC advances, whether the fetched word is
//            forwarded to decode or replaced by a NOOP bubble, and when the
//            execute-stage branch/JAL target is loaded into the PC.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            iMemIn, iMemValid    - instruction word and its valid flag
//            isCtrlXfer           - predecode: word is a BRANCH or JAL
//            downstreamStall      - decode cannot accept this cycle
//            execResolved         - execute has the transfer outcome
//            pcWrtEn, pcSelTarget - PC write enable / target select
//            instruction          - word forwarded to decode
//            busyCtrl, waitCount  - registered transfer status / bubble count
//            protoErr             - sticky: execResolved with nothing pending
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int              DBITS       = 32,
  parameter int              BRANCH_WAIT = 2,
  parameter logic [DBITS-1:0] NOOP_WORD  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] iMemIn,
  input  logic             iMemValid,
  input  logic             isCtrlXfer,
  input  logic             downstreamStall,
  input  logic             execResolved,
  output logic             pcWrtEn,
  output logic             pcSelTarget,
  output logic [DBITS-1:0] instruction,
  output logic             busyCtrl,
  output logic [2:0]       waitCount,
  output logic             protoErr
);

  localparam logic [2:0] c_BRANCH_WAIT = 3'(BRANCH_WAIT);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic       busy_q, busy_d;
  logic       proto_err_q, proto_err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= 3'd0;
      busy_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      busy_q      <= busy_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    busy_d      = busy_q;
    proto_err_d = proto_err_q;
    pcWrtEn     = 1'b0;
    pcSelTarget = 1'b0;
    instruction = NOOP_WORD;

    case (state_q)
      S_RUN: begin
        // Nothing is outstanding, so any resolution is a protocol violation.
        if (execResolved) begin
          proto_err_d = 1'b1;
        end
        if (downstreamStall) begin
          // Word is held on the bus; decode ignores it while stalled.
          instruction = iMemIn;
        end else if (!iMemValid) begin
          instruction = NOOP_WORD;
        end else if (isCtrlXfer) begin
          // The branch itself issues; the PC freezes until it resolves.
          instruction = iMemIn;
          state_d     = S_WAIT;
          wait_cnt_d  = 3'd1;
          busy_d      = 1'b1;
        end else begin
          pcWrtEn     = 1'b1;
          instruction = iMemIn;
        end
      end

      S_WAIT: begin
        if (!downstreamStall) begin
          if (wait_cnt_q < c_BRANCH_WAIT) begin
            // Early resolutions are ignored; the count only saturates.
            wait_cnt_d = wait_cnt_q + 3'd1;
          end else if (execResolved) begin
            pcWrtEn     = 1'b1;
            pcSelTarget = 1'b1;
            state_d     = S_RUN;
            wait_cnt_d  = 3'd0;
            busy_d      = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_RUN;
      end
    endcase

    // Reset abandons any outstanding transfer without redirecting the PC.
    if (reset) begin
      pcWrtEn     = 1'b0;
      pcSelTarget = 1'b0;
      instruction = NOOP_WORD;
    end
  end

  assign busyCtrl  = busy_q;
  assign waitCount = wait_cnt_q;
  assign protoErr  = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Self-checking bench for fetch_sequencer. Each directed cycle
//            pushes its hand-computed expected outputs into a scoreboard
//            queue; a monitor pops and compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  localparam logic [31:0] c_NOOP = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] iMemIn;
  logic        iMemValid;
  logic        isCtrlXfer;
  logic        downstreamStall;
  logic        execResolved;
  logic        pcWrtEn;
  logic        pcSelTarget;
  logic [31:0] instruction;
  logic        busyCtrl;
  logic [2:0]  waitCount;
  logic        protoErr;

  fetch_sequencer #(
    .DBITS       (32),
    .BRANCH_WAIT (2),
    .NOOP_WORD   (c_NOOP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .iMemIn          (iMemIn),
    .iMemValid       (iMemValid),
    .isCtrlXfer      (isCtrlXfer),
    .downstreamStall (downstreamStall),
    .execResolved    (execResolved),
    .pcWrtEn         (pcWrtEn),
    .pcSelTarget     (pcSelTarget),
    .instruction     (instruction),
    .busyCtrl        (busyCtrl),
    .waitCount       (waitCount),
    .protoErr        (protoErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        sel;
    logic [31:0] ins;
    logic        busy;
    logic [2:0]  cnt;
    logic        perr;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: outputs are valid every cycle, so one queued entry per cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ({pcWrtEn, pcSelTarget, instruction, busyCtrl, waitCount, protoErr} !==
          {e.we, e.sel, e.ins, e.busy, e.cnt, e.perr}) begin
        errors++;
        $display("FAIL %s: got we=%b sel=%b ins=%h busy=%b cnt=%0d perr=%b, expected we=%b sel=%b ins=%h busy=%b cnt=%0d perr=%b",
                 e.name, pcWrtEn, pcSelTarget, instruction, busyCtrl, waitCount, protoErr,
                 e.we, e.sel, e.ins, e.busy, e.cnt, e.perr);
      end
    end
  end

  task automatic cyc(
    input logic        rst, input logic [31:0] mem, input logic vld,
    input logic        ctrl, input logic stall, input logic res,
    input logic        we, input logic sel, input logic [31:0] ins,
    input logic        busy, input logic [2:0] cnt, input logic perr,
    input string       name);
    exp_t e;
    @(posedge clk);
    #1;
    reset           = rst;
    iMemIn          = mem;
    iMemValid       = vld;
    isCtrlXfer      = ctrl;
    downstreamStall = stall;
    execResolved    = res;
    e.we = we; e.sel = sel; e.ins = ins; e.busy = busy;
    e.cnt = cnt; e.perr = perr; e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; iMemIn = 32'h0; iMemValid = 1'b0;
    isCtrlXfer = 1'b0; downstreamStall = 1'b0; execResolved = 1'b0;
    repeat (2) @(posedge clk);

    //   rst mem           vld ctl stl res  we sel ins           bsy cnt perr name
    cyc(1, 32'hAAAA_0001, 1, 0, 0, 0,   0, 0, c_NOOP,       0, 0, 0, "reset_forced");
    // Straight-line fetch
    cyc(0, 32'h0000_0011, 1, 0, 0, 0,   1, 0, 32'h0000_0011, 0, 0, 0, "seq_w1");
    cyc(0, 32'h0000_0022, 1, 0, 0, 0,   1, 0, 32'h0000_0022, 0, 0, 0, "seq_w2");
    cyc(0, 32'h0000_0033, 1, 0, 0, 0,   1, 0, 32'h0000_0033, 0, 0, 0, "seq_w3");
    // Basic branch, resolves on last bubble
    cyc(0, 32'hB000_0000, 1, 1, 0, 0,   0, 0, 32'hB000_0000, 0, 0, 0, "br_issue");
    cyc(0, 32'h0000_0044, 1, 1, 0, 0,   0, 0, c_NOOP,       1, 1, 0, "br_bubble1");
    cyc(0, 32'h0000_0044, 1, 0, 0, 1,   1, 1, c_NOOP,       1, 2, 0, "br_redirect");
    cyc(0, 32'h0000_0055, 1, 0, 0, 0,   1, 0, 32'h0000_0055, 0, 0, 0, "br_back_run");
    // Stall inside WAIT freezes the count (early resolve ignored)
    cyc(0, 32'hB100_0000, 1, 1, 0, 0,   0, 0, 32'hB100_0000, 0, 0, 0, "st_issue");
    cyc(0, 32'h0000_0000, 0, 0, 1, 0,   0, 0, c_NOOP,       1, 1, 0, "st_stall1");
    cyc(0, 32'h0000_0000, 0, 0, 1, 1,   0, 0, c_NOOP,       1, 1, 0, "st_stall2");
    cyc(0, 32'h0000_0000, 0, 0, 0, 1,   0, 0, c_NOOP,       1, 1, 0, "st_early_res");
    cyc(0, 32'h0000_0000, 0, 0, 0, 1,   1, 1, c_NOOP,       1, 2, 0, "st_redirect");
    cyc(0, 32'h0000_0066, 1, 0, 0, 0,   1, 0, 32'h0000_0066, 0, 0, 0, "st_back_run");
    // Resolution withheld: saturate at 2
    cyc(0, 32'hB200_0000, 1, 1, 0, 0,   0, 0, 32'hB200_0000, 0, 0, 0, "wh_issue");
    cyc(0, 32'h0000_0000, 1, 0, 0, 0,   0, 0, c_NOOP,       1, 1, 0, "wh_bubble1");
    cyc(0, 32'h0000_0000, 1, 0, 0, 0,   0, 0, c_NOOP,       1, 2, 0, "wh_hold1");
    cyc(0, 32'h0000_0000, 1, 0, 0, 0,   0, 0, c_NOOP,       1, 2, 0, "wh_hold2");
    cyc(0, 32'h0000_0000, 1, 0, 0, 0,   0, 0, c_NOOP,       1, 2, 0, "wh_hold3");
    cyc(0, 32'h0000_0000, 1, 0, 0, 1,   1, 1, c_NOOP,       1, 2, 0, "wh_redirect");
    // RUN stall and invalid memory
    cyc(0, 32'h0000_0077, 1, 0, 1, 0,   0, 0, 32'h0000_0077, 0, 0, 0, "run_stall");
    cyc(0, 32'h0000_0088, 0, 0, 0, 0,   0, 0, c_NOOP,       0, 0, 0, "inv1");
    cyc(0, 32'h0000_0088, 0, 1, 0, 0,   0, 0, c_NOOP,       0, 0, 0, "inv2");
    cyc(0, 32'h0000_0099, 1, 0, 0, 0,   1, 0, 32'h0000_0099, 0, 0, 0, "inv_resume");
    // Protocol error is sticky
    cyc(0, 32'h0000_00AA, 1, 0, 0, 1,   1, 0, 32'h0000_00AA, 0, 0, 0, "perr_trigger");
    cyc(0, 32'h0000_00BB, 1, 0, 0, 0,   1, 0, 32'h0000_00BB, 0, 0, 1, "perr_set");
    cyc(0, 32'h0000_00BC, 1, 0, 0, 0,   1, 0, 32'h0000_00BC, 0, 0, 1, "perr_sticky");
    // Reset in WAIT abandons transfer without redirect
    cyc(0, 32'hB300_0000, 1, 1, 0, 0,   0, 0, 32'hB300_0000, 0, 0, 1, "rw_issue");
    cyc(1, 32'h0000_0000, 1, 0, 0, 1,   0, 0, c_NOOP,       1, 1, 1, "rw_reset");
    cyc(0, 32'h0000_00CC, 1, 0, 0, 0,   1, 0, 32'h0000_00CC, 0, 0, 0, "rw_after");

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control FSM for the instruction fetch stage. Decides each cycle whether the PC advances, whether the fetched word goes to decode or is replaced by a NOOP bubble, and when the execute-stage branch/JAL target is loaded into the PC.
- Sits between instruction memory / predecode and the PC register apparatus. Handles control-transfer wait, instruction-memory not-ready and downstream back-pressure.

Parameters:
- DBITS, 32, datapath width; used only for the NOOP output word.
- BRANCH_WAIT, 2, bubble cycles from issuing a branch/JAL until its outcome is valid in execute (legal range 1..7).
- NOOP_WORD, 32'h0, instruction word injected as a bubble.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- iMemIn  in  DBITS  word returned by instruction memory
- iMemValid  in  1  iMemIn holds a valid instruction this cycle
- isCtrlXfer  in  1  predecode: iMemIn is a BRANCH or JAL; meaningful only when iMemValid=1
- downstreamStall  in  1  decode cannot accept a new instruction this cycle
- execResolved  in  1  execute stage presents a resolved target/cmp for the outstanding control transfer
- pcWrtEn  out  1  PC register write enable
- pcSelTarget  out  1  1 = PC loads the execute-stage target; 0 = PC+4
- instruction  out  DBITS  word forwarded to decode (iMemIn or NOOP_WORD)
- busyCtrl  out  1  registered; a control transfer is outstanding
- waitCount  out  3  registered bubble counter
- protoErr  out  1  registered, sticky; execResolved seen while no transfer is outstanding

Behaviour:
- States: RUN, WAIT. pcWrtEn, pcSelTarget and instruction are combinational (Mealy) from state and inputs. busyCtrl, waitCount and protoErr are registered.
- Reset (synchronous, priority over everything):
  - next state RUN, waitCount=0, busyCtrl=0, protoErr=0.
  - While reset=1: pcWrtEn=0, pcSelTarget=0, instruction=NOOP_WORD.
  - Reset in WAIT abandons the transfer with no redirect.
- RUN, evaluated in this priority order:
  - downstreamStall=1: pcWrtEn=0; instruction=iMemIn (held, decode ignores it); no state change.
  - iMemValid=0: pcWrtEn=0; instruction=NOOP_WORD; stay RUN.
  - iMemValid=1 and isCtrlXfer=1: instruction=iMemIn (the branch itself issues); pcWrtEn=0; go to WAIT; waitCount<=1; busyCtrl<=1.
  - Otherwise: pcWrtEn=1, pcSelTarget=0, instruction=iMemIn.
- WAIT:
  - instruction=NOOP_WORD every cycle; iMemIn and isCtrlXfer are ignored.
  - downstreamStall=1: pcWrtEn=0; waitCount frozen.
  - No stall and waitCount<BRANCH_WAIT: waitCount increments; pcWrtEn=0.
  - No stall, waitCount==BRANCH_WAIT and execResolved=1: pcWrtEn=1, pcSelTarget=1; next state RUN; waitCount<=0; busyCtrl<=0.
  - waitCount==BRANCH_WAIT and execResolved=0: hold in WAIT with count saturated; keep emitting bubbles.
  - execResolved=1 while waitCount<BRANCH_WAIT: ignored.
- protoErr is set when execResolved=1 in state RUN. It clears only on reset.
- Minimum branch cost with no stalls: 1 issue cycle + BRANCH_WAIT bubbles; the redirect happens on the last bubble cycle.
- waitCount never exceeds BRANCH_WAIT and never wraps.

Test Plan:
- Reset, then 3 non-control words (iMemValid=1, isCtrlXfer=0, no stall) -> pcWrtEn=1 and pcSelTarget=0 each cycle; instruction equals each iMemIn; busyCtrl=0.
- Branch at cycle 0, execResolved=1 at cycle 2, BRANCH_WAIT=2:
  - cycle 0: instruction=branch word, pcWrtEn=0.
  - cycles 1-2: NOOP_WORD; waitCount 1→2.
  - cycle 2: pcWrtEn=1, pcSelTarget=1.
  - cycle 3: state RUN, busyCtrl=0.
- Branch, then downstreamStall=1 for 2 cycles in WAIT -> waitCount frozen at 1; redirect delayed exactly 2 cycles; instruction=NOOP_WORD throughout.
- execResolved withheld for 3 extra cycles after waitCount=2 -> stays in WAIT; waitCount=2; pcWrtEn=0; redirects in the cycle execResolved rises.
- iMemValid=0 for 2 cycles in RUN -> pcWrtEn=0 and instruction=NOOP_WORD; PC resumes on the next valid word. Separately, execResolved=1 in RUN -> protoErr=1 until reset.
- reset=1 asserted in WAIT with waitCount=1 -> next cycle state RUN, waitCount=0, busyCtrl=0; no pcSelTarget pulse.
